snn_input_loader: RTL
=====================

Name: snn_input_loader

Overview:
- Writer side of the SNN core's 1-bit input image RAM.
- Receives packed image bytes from the UART receiver and unpacks them LSB-first into the input RAM, one pixel per cycle.
- When the image is complete, pulses start to snn_core and waits for done.
- Returns the classified digit as an ASCII byte to the UART transmitter, then re-arms for the next image.

Parameters:
- NUM_PIXELS, 784, pixels per image (28x28); NUM_BYTES = ceil(NUM_PIXELS/8) = 98.
- ADDR_WIDTH, 10, width of the input RAM address.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock; reset is synchronous and active-high
- rx_rdy  in  1  one-cycle strobe, rx_data valid
- rx_data  in  8  received image byte, pixel 8n+k in bit k
- ram_we  out  1  input RAM write enable
- ram_addr  out  ADDR_WIDTH  input RAM write address
- ram_data  out  1  pixel value written
- snn_start  out  1  one-cycle start pulse to snn_core
- snn_done  in  1  snn_core done (level-sampled)
- snn_digit  in  4  snn_core result, valid while snn_done high
- tx_start  out  1  one-cycle transmit request
- tx_data  out  8  ASCII result byte
- tx_done  in  1  transmitter finished
- busy  out  1  high in every state except IDLE
- overrun  out  1  sticky; a received byte was dropped

Behaviour:
- Reset (synchronous, highest priority, any state):
  - state=IDLE; byte counter and bit counter cleared.
  - pending buffer emptied.
  - All outputs 0, including overrun.
  - A partially loaded image is abandoned; the next accepted byte writes address 0.
- States: IDLE, LOAD, START, WAIT_DONE, SEND, WAIT_TX.
- IDLE:
  - rx_rdy at edge t latches rx_data into the shift register; go to LOAD.
- LOAD:
  - Cycles t+1..t+8: ram_we=1, ram_addr=8*byte_cnt+k, ram_data=bit k, for k=0..7.
  - ram_addr is ADDR_WIDTH bits, no wrap; the last write is address NUM_PIXELS-1 (783).
- Buffering:
  - One pending-byte register.
  - rx_rdy while LOAD is unpacking and pending empty: store byte in pending.
  - Pending full: drop byte, set overrun.
  - After bit 7 of a byte, if pending is full, its bit 0 is written the very next cycle (no bubble); otherwise ram_we=0 and the block waits in LOAD.
  - rx_rdy in the same cycle pending drains is accepted into pending.
- Final byte:
  - After the write of address 783, go to START.
  - A pending byte still held at that point is discarded and sets overrun.
- START:
  - snn_start=1 for exactly one cycle (the cycle after the write of address 783), then WAIT_DONE.
- WAIT_DONE:
  - Hold until snn_done=1; capture snn_digit that cycle; go to SEND.
- SEND:
  - tx_start=1 for one cycle.
  - tx_data = 8'h30+digit for digit 0..9; 8'h3F ('?') for 10..15.
  - tx_data holds until the next image's SEND.
  - Then WAIT_TX.
- WAIT_TX:
  - Hold until tx_done=1, then IDLE.
- rx_rdy in START, WAIT_DONE, SEND or WAIT_TX: byte dropped, overrun set.
- ram_we is never high outside LOAD.
- snn_start and tx_start are each high for at most one cycle per image.
- overrun clears only on rst.

Test Plan:
- Full image: 98 bytes of 8'hFF, rx_rdy spaced 10 cycles -> 784 writes, addr 0..783 ascending, data all 1; single snn_start the cycle after the addr-783 write; no overrun.
- Bit order: first byte 8'hA5 -> addr 0..7 written 1,0,1,0,0,1,0,1; second byte 8'h01 -> addr 8=1, addr 9..15=0.
- Back-to-back: rx_rdy on two consecutive cycles (8'h0F, 8'hF0) -> 16 consecutive ram_we cycles, addr 0..15, data 1111000000001111; overrun=0. Three bytes within 8 cycles -> third dropped, overrun=1, only 16 writes.
- Result: after load, snn_done=1 with snn_digit=7 -> one tx_start cycle, tx_data=8'h37; snn_digit=12 -> tx_data=8'h3F; state returns to IDLE (busy=0) only after tx_done.
- Reset mid-load: rst after 40 bytes, then one byte 8'h03 -> writes addr 0=1, 1=1, 2..7=0; overrun=0; no snn_start.
- Bytes during WAIT_DONE: rx_rdy while awaiting snn_done -> no RAM write, overrun=1; the following image still loads from addr 0.

Source files
------------

// File: rtl/snn_input_loader.sv
// Writer side of the SNN input image RAM: unpacks UART bytes LSB-first into
// 1-bit pixels, kicks snn_core, and returns the digit as an ASCII byte.
module snn_input_loader #(
  parameter int NUM_PIXELS = 784,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_rdy,
  input  logic [7:0]            rx_data,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_data,
  output logic                  snn_start,
  input  logic                  snn_done,
  input  logic [3:0]            snn_digit,
  output logic                  tx_start,
  output logic [7:0]            tx_data,
  input  logic                  tx_done,
  output logic                  busy,
  output logic                  overrun
);

  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_DONE, SEND, WAIT_TX} state_t;

  state_t     state;
  logic [7:0] shreg;
  logic [2:0] bit_cnt;
  logic       pend_vld;
  logic [7:0] pend_data;
  logic       last_wr;
  logic       nxt_vld;
  logic [7:0] nxt_byte;

  // ram_addr always holds the address of the most recent write
  assign last_wr  = ram_we && (ram_addr == ADDR_WIDTH'(NUM_PIXELS - 1));
  assign nxt_vld  = pend_vld || rx_rdy;
  assign nxt_byte = pend_vld ? pend_data : rx_data;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      pend_vld  <= 1'b0;
      pend_data <= '0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_data  <= 1'b0;
      snn_start <= 1'b0;
      tx_start  <= 1'b0;
      tx_data   <= '0;
      overrun   <= 1'b0;
    end else begin
      snn_start <= 1'b0;
      tx_start  <= 1'b0;
      if (rx_rdy && (state inside {START, WAIT_DONE, SEND, WAIT_TX}))
        overrun <= 1'b1;
      case (state)
        IDLE: if (rx_rdy) begin
          shreg    <= rx_data;
          ram_data <= rx_data[0];
          ram_we   <= 1'b1;
          ram_addr <= '0;
          bit_cnt  <= '0;
          state    <= LOAD;
        end
        LOAD: begin
          if (last_wr) begin
            // a byte still waiting here has no room in this image
            ram_we    <= 1'b0;
            snn_start <= 1'b1;
            pend_vld  <= 1'b0;
            if (nxt_vld) overrun <= 1'b1;
            state     <= START;
          end else if (ram_we && bit_cnt != 3'd7) begin
            shreg    <= shreg >> 1;
            ram_data <= shreg[1];
            ram_addr <= ram_addr + 1'b1;
            bit_cnt  <= bit_cnt + 3'd1;
            if (rx_rdy) begin
              if (pend_vld) overrun <= 1'b1;
              else begin
                pend_vld  <= 1'b1;
                pend_data <= rx_data;
              end
            end
          end else if (nxt_vld) begin
            shreg    <= nxt_byte;
            ram_data <= nxt_byte[0];
            ram_we   <= 1'b1;
            ram_addr <= ram_addr + 1'b1;
            bit_cnt  <= '0;
            if (pend_vld) begin
              pend_vld  <= rx_rdy;
              pend_data <= rx_data;
            end
          end else begin
            ram_we <= 1'b0;
          end
        end
        START: state <= WAIT_DONE;
        WAIT_DONE: if (snn_done) begin
          tx_start <= 1'b1;
          tx_data  <= (snn_digit < 4'd10) ? (8'h30 + {4'h0, snn_digit}) : 8'h3F;
          state    <= SEND;
        end
        SEND: state <= WAIT_TX;
        WAIT_TX: if (tx_done) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
